block_data_memory: RTL and testbench
====================================

# block_data_memory

Block-granularity, fixed-latency backing memory that answers the cache's line-fill and write-back requests. It is the responder end of the cache-to-memory handshake (is_input_valid / mem_ready / is_output_valid): it accepts one whole-line read or write at a time, stalls for a programmable latency, then commits the write or returns the line. It sits directly below the cache and is the only path to main storage.

## Interface
- BLOCK_SIZE, 16: line size in bytes, power of two, ≥4; data ports are BLOCK_SIZE*8 bits wide.
- NUM_BLOCKS, 256: number of lines stored, power of two.
- DELAY, 4: access latency in cycles, ≥1.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high.
- is_input_valid  input  1  request present this cycle.
- addr  input  32  byte address of the line; offset bits are ignored.
- mem_read  input  1  request is a line read.
- mem_write  input  1  request is a line write.
- din  input  BLOCK_SIZE*8  write line data.
- mem_ready  output  1  responder idle; a request is accepted this cycle.
- is_output_valid  output  1  dout holds read data; one-cycle pulse.
- dout  output  BLOCK_SIZE*8  read line data.

## Operation
- Line index = addr[OFF+IDX-1:OFF], with OFF = log2(BLOCK_SIZE) and IDX = log2(NUM_BLOCKS). Upper address bits are dropped, so addresses wrap modulo NUM_BLOCKS lines.
- States:
  - IDLE: mem_ready=1.
  - BUSY: mem_ready=0, down-counter active.
- Acceptance: at an edge in IDLE with is_input_valid=1 and (mem_read|mem_write)=1:
  - latch index, operation and din;
  - load counter with DELAY;
  - go to BUSY.
- is_input_valid with neither read nor write asserted is ignored. The FSM stays in IDLE.
- mem_read and mem_write both high: treated as a write. No read response is produced.
- In BUSY, all inputs are ignored; there is no queueing. The initiator re-presents the request once mem_ready returns.
- BUSY, counter decrements each edge. On the edge where it is 1:
  - write: array[index] ← latched din;
  - read: dout ← array[index], is_output_valid ← 1;
  - go to IDLE.
- The array write and the read use the latched values. Changes on din or addr after acceptance have no effect.
- dout holds the last read line until the next read completes. Writes never change dout.

## Timing
- Reset values: mem_ready=1, is_output_valid=0, dout=0, state IDLE, counter 0.
- Acceptance at edge E0. mem_ready=0 in the cycles following edges E0..E(DELAY−1).
- Completion at edge E(DELAY). In the cycle that follows:
  - mem_ready=1;
  - is_output_valid=1 (reads only);
  - dout is valid.
- is_output_valid drops at the next edge.
- Back-to-back: a new request presented in the response cycle is accepted at edge E(DELAY+1). Sustained rate is one request per DELAY+1 cycles.
- A read issued after a write to the same line returns the written data. Write commit precedes the next acceptance.
- Reset mid-operation (BUSY) has the following effects:
  - the request is aborted and a pending write is discarded;
  - no is_output_valid pulse is produced;
  - mem_ready=1 the next cycle.
- Reset also takes priority over acceptance and completion in the same cycle.

## Configuration
- DMEM_RESET_CLEAR_EN:
  - Defined: synchronous reset also zeroes every array line, taking effect in the same edge.
  - Undefined: array contents survive reset. They are zero only at simulation start, via initial block; only control state and outputs are reset.

## Test plan
- Reset, then read addr 0x0000_0040 with DELAY=4 → mem_ready low 4 cycles, then is_output_valid=1 for exactly one cycle with dout=0.
- Write line 0x1111…_2222 to addr 0x0000_0130, then read addr 0x0000_013C → dout=0x1111…_2222 (offset bits ignored); no is_output_valid pulse on the write.
- Write data A to addr 0x0000_0010, then read addr 0x0000_1010 (NUM_BLOCKS=256, BLOCK_SIZE=16) → wraps to the same line and returns A.
- Toggle is_input_valid/addr/din while BUSY → ignored; completion uses the original request; a request in the response cycle is accepted with mem_ready low from the next cycle.
- Assert reset at the 2nd BUSY cycle of a write of B over old data C → no pulse, mem_ready=1 next cycle. A subsequent read returns C without the macro, and 0 with DMEM_RESET_CLEAR_EN.
- mem_read=mem_write=1 with data D → no is_output_valid; a later read of that line returns D.

Source files
------------

// File: rtl/block_data_memory_if.sv
// block_data_memory_if
//   Cache-to-memory line handshake bundle.
//   master (cache side) drives : is_input_valid, addr, mem_read, mem_write, din
//   slave  (memory side) drives: mem_ready, is_output_valid, dout
//   BLOCK_SIZE : line size in bytes; din/dout are BLOCK_SIZE*8 bits wide.
interface block_data_memory_if #(
   parameter int BLOCK_SIZE = 16
);
   logic                      is_input_valid;
   logic [31:0]               addr;
   logic                      mem_read;
   logic                      mem_write;
   logic [BLOCK_SIZE*8-1:0]   din;
   logic                      mem_ready;
   logic                      is_output_valid;
   logic [BLOCK_SIZE*8-1:0]   dout;

   modport master (
      output is_input_valid, addr, mem_read, mem_write, din,
      input  mem_ready, is_output_valid, dout
   );

   modport slave (
      input  is_input_valid, addr, mem_read, mem_write, din,
      output mem_ready, is_output_valid, dout
   );
endinterface

// File: rtl/block_data_memory.sv
// block_data_memory
//   Fixed-latency, line-granular backing memory below the cache. Accepts one
//   whole-line read or write while idle, stays busy for DELAY cycles, then
//   commits the write or returns the line with a one-cycle is_output_valid.
//
// Ports
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : block_data_memory_if.slave
//            is_input_valid/addr/mem_read/mem_write/din in,
//            mem_ready/is_output_valid/dout out
//
// Parameters
//   BLOCK_SIZE : bytes per line (power of two, >= 4)
//   NUM_BLOCKS : lines stored (power of two, >= 2)
//   DELAY      : access latency in cycles (>= 1)
//
// Build option
//   DMEM_RESET_CLEAR_EN : when defined, reset also zeroes every line of the
//                         array; otherwise contents survive reset.
module block_data_memory #(
   parameter int BLOCK_SIZE = 16,
   parameter int NUM_BLOCKS = 256,
   parameter int DELAY      = 4
) (
   input  logic                clk,
   input  logic                reset,
   block_data_memory_if.slave  bus
);

   localparam int W   = BLOCK_SIZE * 8;
   localparam int OFF = $clog2(BLOCK_SIZE);
   localparam int IDX = $clog2(NUM_BLOCKS);
   localparam int CW  = $clog2(DELAY + 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t           state_q,   state_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [IDX-1:0]   idx_q,     idx_d;
   logic             wr_q,      wr_d;
   logic [W-1:0]     data_q,    data_d;
   logic [W-1:0]     dout_q,    dout_d;
   logic             valid_q,   valid_d;
   logic             mem_we;

   // Contents start at zero; only the optional reset clear touches them again.
   logic [W-1:0]     mem_q [NUM_BLOCKS] = '{default: '0};

   // Offset and upper address bits play no part in line selection.
   logic             addr_unused;
   assign addr_unused = &{1'b0, bus.addr[31:OFF+IDX], bus.addr[OFF-1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      data_d  = data_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      mem_we  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.is_input_valid && (bus.mem_read || bus.mem_write)) begin
               idx_d   = bus.addr[OFF+IDX-1:OFF];
               // Read+write together is treated as a write only.
               wr_d    = bus.mem_write;
               data_d  = bus.din;
               cnt_d   = CW'(DELAY);
               state_d = BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               if (wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  dout_d  = mem_q[idx_q];
                  valid_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   // Array update: a write pending at reset is dropped because reset wins.
   always_ff @(posedge clk) begin
      if (reset) begin
`ifdef DMEM_RESET_CLEAR_EN
         for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            mem_q[i] <= '0;
         end
`endif
      end else if (mem_we) begin
         mem_q[idx_q] <= data_q;
      end
   end

   assign bus.mem_ready       = (state_q == IDLE);
   assign bus.is_output_valid = valid_q;
   assign bus.dout            = dout_q;

endmodule

// File: tb/tb_block_data_memory.sv
// tb_block_data_memory
//   Randomized + directed bench for block_data_memory. The driver issues
//   requests and pushes expected read lines into a queue taken from a flat
//   line-array model; the monitor pops and compares on each is_output_valid.
module tb_block_data_memory;

   localparam int BLOCK_SIZE = 16;
   localparam int NUM_BLOCKS = 256;
   localparam int DELAY      = 4;
   localparam int W          = BLOCK_SIZE * 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   block_data_memory_if #(.BLOCK_SIZE(BLOCK_SIZE)) bus ();

   block_data_memory #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .NUM_BLOCKS (NUM_BLOCKS),
      .DELAY      (DELAY)
   ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [W-1:0] model [NUM_BLOCKS];
   logic [W-1:0] exp_q [$];
   logic [W-1:0] hold_dout = '0;
   bit           started   = 1'b0;
   bit           prev_valid = 1'b0;

   function automatic int line_of(input logic [31:0] a);
      return int'((a / BLOCK_SIZE) % NUM_BLOCKS);
   endfunction

   function automatic logic [W-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      if (rst) hold_dout = '0;
   end

   always @(negedge clk) begin
      if (started) begin
         if (bus.is_output_valid === 1'b1) begin
            checks++;
            if (prev_valid) begin
               errors++;
               $display("FAIL valid_pulse_width: is_output_valid high two cycles at %0t", $time);
            end
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: got pulse with dout %h, required no pulse at %0t",
                        bus.dout, $time);
            end else begin
               hold_dout = exp_q.pop_front();
               check("read_data", bus.dout, hold_dout);
            end
         end else begin
            check("dout_hold", bus.dout, hold_dout);
         end
         prev_valid = (bus.is_output_valid === 1'b1);
      end
   end

   // ---------------- driver ----------------
   task automatic idle_inputs();
      bus.is_input_valid = 1'b0;
      bus.mem_read       = 1'b0;
      bus.mem_write      = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge of the response cycle.
   task automatic issue(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [W-1:0] d, input bit toggle_busy);
      int n = 0;
      while (bus.mem_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.mem_ready !== 1'b1) begin
         check("ready_timeout", W'(bus.mem_ready), W'(1));
         return;
      end
      bus.is_input_valid = 1'b1;
      bus.addr           = a;
      bus.mem_read       = rd;
      bus.mem_write      = wr;
      bus.din            = d;
      if (!rd && !wr) begin
         @(posedge clk);
         @(negedge clk);
         check("ignored_req_ready", W'(bus.mem_ready), W'(1));
         idle_inputs();
         return;
      end
      if (wr) model[line_of(a)] = d;
      else    exp_q.push_back(model[line_of(a)]);
      @(posedge clk);
      for (int k = 0; k < DELAY; k++) begin
         @(negedge clk);
         check("busy_ready_low", W'(bus.mem_ready), W'(0));
         if (toggle_busy) begin
            bus.is_input_valid = 1'($urandom);
            bus.addr           = $urandom;
            bus.mem_read       = 1'($urandom);
            bus.mem_write      = 1'($urandom);
            bus.din            = rand_line();
         end else begin
            idle_inputs();
         end
      end
      @(negedge clk);
      check("response_ready_high", W'(bus.mem_ready), W'(1));
      idle_inputs();
   endtask

   logic [W-1:0] pat_a, pat_b, pat_c, pat_d, pat_x;
   logic [31:0]  ra;
   int           op;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NUM_BLOCKS; i++) model[i] = '0;
      idle_inputs();
      bus.addr = '0;
      bus.din  = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ready", W'(bus.mem_ready), W'(1));
      check("reset_valid", W'(bus.is_output_valid), W'(0));
      check("reset_dout", bus.dout, '0);
      started = 1'b1;
      rst = 1'b0;
      @(negedge clk);

      // Read of a never-written line.
      issue(32'h0000_0040, 1'b1, 1'b0, '0, 1'b0);

      // Write then read with nonzero offset bits.
      pat_x = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
      issue(32'h0000_0130, 1'b0, 1'b1, pat_x, 1'b0);
      issue(32'h0000_013C, 1'b1, 1'b0, '0, 1'b0);

      // Address wrap modulo NUM_BLOCKS lines.
      pat_a = rand_line();
      issue(32'h0000_0010, 1'b0, 1'b1, pat_a, 1'b0);
      issue(32'h0000_1010, 1'b1, 1'b0, '0, 1'b0);

      // Inputs wiggling while busy, then a back-to-back read in the response cycle.
      pat_x = rand_line();
      issue(32'h0000_0500, 1'b0, 1'b1, pat_x, 1'b1);
      issue(32'h0000_0504, 1'b1, 1'b0, '0, 1'b1);
      issue(32'h0000_0500, 1'b1, 1'b0, '0, 1'b0);

      // Reset in the 2nd busy cycle of a write over existing data.
      pat_c = rand_line();
      pat_b = ~pat_c;
      issue(32'h0000_0200, 1'b0, 1'b1, pat_c, 1'b0);
      bus.is_input_valid = 1'b1;
      bus.addr           = 32'h0000_0200;
      bus.mem_read       = 1'b0;
      bus.mem_write      = 1'b1;
      bus.din            = pat_b;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      check("abort_busy1", W'(bus.mem_ready), W'(0));
      @(negedge clk);
      check("abort_busy2", W'(bus.mem_ready), W'(0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", W'(bus.mem_ready), W'(1));
      check("abort_no_valid", W'(bus.is_output_valid), W'(0));
`ifdef DMEM_RESET_CLEAR_EN
      for (int i = 0; i < NUM_BLOCKS; i++) model[i] = '0;
`endif
      @(negedge clk);
      issue(32'h0000_0200, 1'b1, 1'b0, '0, 1'b0);

      // Read and write together behaves as a write.
      pat_d = rand_line();
      issue(32'h0000_0300, 1'b1, 1'b1, pat_d, 1'b0);
      issue(32'h0000_0300, 1'b1, 1'b0, '0, 1'b0);

      // Valid with no operation is ignored.
      issue(32'h0000_0300, 1'b0, 1'b0, rand_line(), 1'b0);

      // Random traffic over a small line pool with random upper/offset bits.
      for (int t = 0; t < 80; t++) begin
         ra = {$urandom_range(0, 15), 4'h0, $urandom_range(0, 7), 4'h0}
              | 32'($urandom_range(0, 15)) | {$urandom_range(0, 255), 24'h0};
         op = $urandom_range(0, 9);
         if (op < 5)       issue(ra, 1'b1, 1'b0, rand_line(), 1'($urandom));
         else if (op < 8)  issue(ra, 1'b0, 1'b1, rand_line(), 1'($urandom));
         else if (op < 9)  issue(ra, 1'b1, 1'b1, rand_line(), 1'b0);
         else              issue(ra, 1'b0, 1'b0, rand_line(), 1'b0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_responses: got %0d outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
